// File: rtl/sprite_line_fetcher_if.sv
// Sprite ROM request/response bundle.
// The line fetcher is the master: it drives the request and reads the registered line data.
interface sprite_line_fetcher_if;
    logic [3:0] rom_sprite_id;
    logic [1:0] rom_orientation;
    logic [2:0] rom_line_index;
    logic [7:0] rom_data;

    modport master (
        output rom_sprite_id,
        output rom_orientation,
        output rom_line_index,
        input  rom_data
    );

    modport slave (
        input  rom_sprite_id,
        input  rom_orientation,
        input  rom_line_index,
        output rom_data
    );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite line fetch into shadow slots, with a double-buffered copy to active slots.
// Also provides a registered per-pixel hit and winning-slot output for the colour mux.
module sprite_line_fetcher #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SCALE_LOG2 = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SLOTS-1:0]    ent_en,
    input  logic [4*NUM_SLOTS-1:0]  ent_id,
    input  logic [2*NUM_SLOTS-1:0]  ent_orient,
    input  logic [10*NUM_SLOTS-1:0] ent_x,
    input  logic [10*NUM_SLOTS-1:0] ent_y,
    input  logic                    line_start,
    input  logic [9:0]              fetch_y,
    input  logic [9:0]              pixel_x,
    sprite_line_fetcher_if.master   rom,
    output logic                    fetch_busy,
    output logic                    fetch_done,
    output logic                    pixel_on,
    output logic [2:0]              pixel_slot
);

    localparam logic [10:0] S_L  = 11'(8 << SCALE_LOG2);
    localparam logic [2:0]  LAST = 3'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

    state_t     state_q;
    logic [2:0] idx_q;
    logic [9:0] fy_q;
    logic       hit_q;
    logic [3:0] rom_id_q;
    logic [1:0] rom_or_q;
    logic [2:0] rom_ln_q;
    logic       busy_q;
    logic       done_q;
    logic       pix_on_q;
    logic [2:0] pix_slot_q;

    logic [7:0] shadow_buf_q [NUM_SLOTS];
    logic       shadow_val_q [NUM_SLOTS];
    logic [9:0] shadow_x_q   [NUM_SLOTS];
    logic [7:0] act_buf_q    [NUM_SLOTS];
    logic       act_val_q    [NUM_SLOTS];
    logic [9:0] act_x_q      [NUM_SLOTS];

    // Entity fields unpacked into 8-deep arrays so a 3-bit slot index is always in range.
    logic       en_a [8];
    logic [3:0] id_a [8];
    logic [1:0] or_a [8];
    logic [9:0] x_a  [8];
    logic [9:0] y_a  [8];

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            en_a[i] = 1'b0;
            id_a[i] = '0;
            or_a[i] = '0;
            x_a[i]  = '0;
            y_a[i]  = '0;
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            en_a[i] = ent_en[i];
            id_a[i] = ent_id[4*i +: 4];
            or_a[i] = ent_orient[2*i +: 2];
            x_a[i]  = ent_x[10*i +: 10];
            y_a[i]  = ent_y[10*i +: 10];
        end
    end

    // The request for slot i is computed on the edge that enters ISSUE(i),
    // so it looks ahead to the slot about to be issued.
    logic [2:0] nxt_slot;
    logic [9:0] y_ref;
    logic [9:0] dy;
    logic       req_hit;
    logic       do_issue;

    always_comb begin
        nxt_slot = (state_q == S_CAPTURE) ? idx_q + 3'd1 : '0;
        y_ref    = (state_q == S_IDLE) ? fetch_y : fy_q;
        dy       = y_ref - y_a[nxt_slot];
        req_hit  = en_a[nxt_slot] && ({1'b0, dy} < S_L);
        do_issue = ((state_q == S_IDLE) && line_start) ||
                   ((state_q == S_CAPTURE) && (idx_q != LAST));
    end

    logic       pix_on_d;
    logic [2:0] pix_slot_d;
    logic [9:0] dx;

    always_comb begin
        pix_on_d   = 1'b0;
        pix_slot_d = '0;
        dx         = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            dx = pixel_x - act_x_q[i];
            if (!pix_on_d && act_val_q[i] && ({1'b0, dx} < S_L) &&
                !act_buf_q[i][3'(dx >> SCALE_LOG2)]) begin
                pix_on_d   = 1'b1;
                pix_slot_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            fy_q       <= '0;
            hit_q      <= 1'b0;
            rom_id_q   <= 4'hF;
            rom_or_q   <= '0;
            rom_ln_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pix_on_q   <= 1'b0;
            pix_slot_q <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                shadow_buf_q[i] <= '1;
                shadow_val_q[i] <= 1'b0;
                shadow_x_q[i]   <= '0;
                act_buf_q[i]    <= '1;
                act_val_q[i]    <= 1'b0;
                act_x_q[i]      <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            pix_on_q   <= pix_on_d;
            pix_slot_q <= pix_slot_d;

            if (do_issue) begin
                hit_q    <= req_hit;
                rom_id_q <= req_hit ? id_a[nxt_slot] : 4'hF;
                rom_or_q <= req_hit ? or_a[nxt_slot] : 2'd0;
                rom_ln_q <= req_hit ? 3'(dy >> SCALE_LOG2) : 3'd0;
            end

            case (state_q)
                S_IDLE: begin
                    if (line_start) begin
                        fy_q    <= fetch_y;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (idx_q == 3'(i)) begin
                            shadow_buf_q[i] <= rom.rom_data;
                            shadow_val_q[i] <= hit_q;
                            shadow_x_q[i]   <= x_a[i];
                        end
                    end
                    if (idx_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        act_buf_q[i] <= shadow_buf_q[i];
                        act_val_q[i] <= shadow_val_q[i];
                        act_x_q[i]   <= shadow_x_q[i];
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom.rom_sprite_id   = rom_id_q;
    assign rom.rom_orientation = rom_or_q;
    assign rom.rom_line_index  = rom_ln_q;
    assign fetch_busy          = busy_q;
    assign fetch_done          = done_q;
    assign pixel_on            = pix_on_q;
    assign pixel_slot          = pix_slot_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: ROM model on the slave modport, reference model of
// the fetched lines, and scoreboard queues for ROM requests and pixel results.
module tb_sprite_line_fetcher;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NS-1:0]   ent_en;
    logic [4*NS-1:0] ent_id;
    logic [2*NS-1:0] ent_orient;
    logic [10*NS-1:0] ent_x;
    logic [10*NS-1:0] ent_y;
    logic            line_start;
    logic [9:0]      fetch_y;
    logic [9:0]      pixel_x;
    logic            fetch_busy;
    logic            fetch_done;
    logic            pixel_on;
    logic [2:0]      pixel_slot;

    logic       e_en [NS];
    logic [3:0] e_id [NS];
    logic [1:0] e_or [NS];
    logic [9:0] e_x  [NS];
    logic [9:0] e_y  [NS];

    logic       m_val [NS];
    logic [7:0] m_buf [NS];
    logic [9:0] m_x   [NS];

    typedef struct {
        bit         hit;
        logic [3:0] id;
        logic [1:0] ori;
        logic [2:0] ln;
    } req_t;

    req_t       req_q [$];
    logic [3:0] pix_q [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_line_fetcher_if rom_if ();

    sprite_line_fetcher #(
        .NUM_SLOTS (NS),
        .SCALE_LOG2(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ent_en    (ent_en),
        .ent_id    (ent_id),
        .ent_orient(ent_orient),
        .ent_x     (ent_x),
        .ent_y     (ent_y),
        .line_start(line_start),
        .fetch_y   (fetch_y),
        .pixel_x   (pixel_x),
        .rom       (rom_if),
        .fetch_busy(fetch_busy),
        .fetch_done(fetch_done),
        .pixel_on  (pixel_on),
        .pixel_slot(pixel_slot)
    );

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            ent_en[i]             = e_en[i];
            ent_id[4*i +: 4]      = e_id[i];
            ent_orient[2*i +: 2]  = e_or[i];
            ent_x[10*i +: 10]     = e_x[i];
            ent_y[10*i +: 10]     = e_y[i];
        end
    end

    // Sprite ROM stand-in: blank for ID F, otherwise a line pattern rotated by orientation.
    function automatic logic [7:0] rom_model(input logic [3:0] id, input logic [1:0] ori,
                                             input logic [2:0] ln);
        logic [7:0]  b;
        logic [15:0] w;
        if (id == 4'hF) return 8'hFF;
        b = ~(8'(8'h03 << (ln ^ 3'd3))) ^ {id, 4'h0};
        w = {b, b} << (2 * ori);
        return w[15:8];
    endfunction

    always @(posedge clk)
        rom_if.rom_data <= rom_model(rom_if.rom_sprite_id, rom_if.rom_orientation,
                                     rom_if.rom_line_index);

    function automatic logic [3:0] exp_pix(input logic [9:0] x);
        logic [9:0] d;
        for (int i = 0; i < NS; i++) begin
            d = x - m_x[i];
            if (m_val[i] && d < 10'd16 && m_buf[i][d[3:1]] == 1'b0)
                return {1'b1, 3'(i)};
        end
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) begin
            m_val[i] = 1'b0;
            m_buf[i] = 8'hFF;
            m_x[i]   = '0;
        end
    endtask

    // Called at a falling edge; returns one falling edge later with the result checked.
    task automatic px(input logic [9:0] x);
        logic [3:0] e;
        pixel_x = x;
        pix_q.push_back(exp_pix(x));
        @(negedge clk);
        e = pix_q.pop_front();
        chk($sformatf("pixel_on@x=%0d", x), pixel_on, e[3]);
        chk($sformatf("pixel_slot@x=%0d", x), pixel_slot, e[2:0]);
    endtask

    task automatic do_fetch(input logic [9:0] fy, input bit extra_pulse);
        logic       nv [NS];
        logic [7:0] nb [NS];
        logic [9:0] nx [NS];
        logic [9:0] d;
        req_t       r;
        for (int i = 0; i < NS; i++) begin
            d     = fy - e_y[i];
            r.hit = e_en[i] && (d < 10'd16);
            r.id  = r.hit ? e_id[i] : 4'hF;
            r.ori = e_or[i];
            r.ln  = d[3:1];
            req_q.push_back(r);
            nv[i] = r.hit;
            nb[i] = r.hit ? rom_model(e_id[i], e_or[i], d[3:1]) : 8'hFF;
            nx[i] = e_x[i];
        end
        line_start = 1'b1;
        fetch_y    = fy;
        @(negedge clk);
        line_start = 1'b0;
        fetch_y    = ~fy;
        for (int c = 1; c <= 10; c++) begin
            if ((c % 2) == 1 && c <= 2*NS - 1) begin
                r = req_q.pop_front();
                chk($sformatf("rom_sprite_id@issue%0d", c/2), rom_if.rom_sprite_id, r.id);
                if (r.hit) begin
                    chk($sformatf("rom_orientation@issue%0d", c/2), rom_if.rom_orientation, r.ori);
                    chk($sformatf("rom_line_index@issue%0d", c/2), rom_if.rom_line_index, r.ln);
                end
            end
            chk($sformatf("fetch_busy@c%0d", c), fetch_busy, (c <= 2*NS + 1));
            chk($sformatf("fetch_done@c%0d", c), fetch_done, (c == 2*NS + 1));
            line_start = extra_pulse && (c == 3);
            if (c == 3) fetch_y = 10'd700;
            @(negedge clk);
        end
        line_start = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_val[i] = nv[i];
            m_buf[i] = nb[i];
            m_x[i]   = nx[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        line_start = 1'b0;
        fetch_y    = '0;
        pixel_x    = '0;
        for (int i = 0; i < NS; i++) begin
            e_en[i] = 1'b0;
            e_id[i] = '0;
            e_or[i] = '0;
            e_x[i]  = '0;
            e_y[i]  = '0;
        end
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset rom_sprite_id", rom_if.rom_sprite_id, 4'hF);
        chk("reset rom_orientation", rom_if.rom_orientation, 2'd0);
        chk("reset rom_line_index", rom_if.rom_line_index, 3'd0);
        chk("reset fetch_busy", fetch_busy, 1'b0);
        chk("reset fetch_done", fetch_done, 1'b0);
        px(10'd0);
        px(10'd100);
        px(10'd1023);
        reset = 1'b1;
        @(negedge clk);

        // Single slot, UP: line 3 of sprite 0 lights columns 100..103
        e_en[0] = 1'b1; e_id[0] = 4'd0; e_or[0] = 2'd0; e_x[0] = 10'd100; e_y[0] = 10'd50;
        do_fetch(10'd56, 1'b0);
        for (int x = 98; x <= 117; x++) px(10'(x));

        // Y miss: entity below the line wraps to a large dy
        e_y[0] = 10'd60;
        do_fetch(10'd56, 1'b0);
        for (int x = 99; x <= 105; x++) px(10'(x));

        // Wraparound hit: top edge near 1023, line 2
        e_y[0] = 10'd1022;
        do_fetch(10'd2, 1'b0);
        for (int x = 98; x <= 117; x++) px(10'(x));

        // Priority: slots 0 and 2 overlap, slot 1 misses
        e_en[0] = 1'b1; e_id[0] = 4'd0; e_x[0] = 10'd200; e_y[0] = 10'd100;
        e_en[1] = 1'b1; e_id[1] = 4'd3; e_x[1] = 10'd400; e_y[1] = 10'd300;
        e_en[2] = 1'b1; e_id[2] = 4'd1; e_x[2] = 10'd200; e_y[2] = 10'd100;
        do_fetch(10'd100, 1'b0);
        for (int x = 204; x <= 211; x++) px(10'(x));
        e_en[0] = 1'b0;
        do_fetch(10'd100, 1'b0);
        for (int x = 204; x <= 211; x++) px(10'(x));

        // Second line_start while busy is ignored
        do_fetch(10'd100, 1'b1);
        for (int x = 205; x <= 208; x++) px(10'(x));

        // Reset during CAPTURE(1)
        e_en[1] = 1'b0; e_en[2] = 1'b0;
        e_en[0] = 1'b1; e_id[0] = 4'd0; e_x[0] = 10'd100; e_y[0] = 10'd50;
        do_fetch(10'd56, 1'b0);
        px(10'd101);
        line_start = 1'b1;
        fetch_y    = 10'd56;
        @(negedge clk);
        line_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy@capture1", fetch_busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("midreset fetch_busy", fetch_busy, 1'b0);
        chk("midreset pixel_on", pixel_on, 1'b0);
        chk("midreset rom_sprite_id", rom_if.rom_sprite_id, 4'hF);
        clear_model();
        @(negedge clk);
        px(10'd101);
        reset = 1'b1;
        px(10'd101);
        do_fetch(10'd56, 1'b0);
        px(10'd101);

        // Orientation LEFT passthrough
        e_id[0] = 4'd2; e_or[0] = 2'd3; e_x[0] = 10'd300; e_y[0] = 10'd200;
        do_fetch(10'd203, 1'b0);
        for (int x = 298; x <= 317; x++) px(10'(x));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
